// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: ID->EX operand bundle plus EX result/handshake.
// master drives operands, slave (EX) returns busy/out_valid/jump/c.
interface ex_stage_mc_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] z_;
   logic            flush;
   logic            busy;
   logic            out_valid;
   logic            jump;
   logic [XLEN-1:0] c;

   modport master (
      output in_valid, opcode, funct3, funct7,
      output pc, data1, data2, imm, z_, flush,
      input  busy, out_valid, jump, c
   );

   modport slave (
      input  in_valid, opcode, funct3, funct7,
      input  pc, data1, data2, imm, z_, flush,
      output busy, out_valid, jump, c
   );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: multi-cycle EX stage, single-cycle base ops plus an
// iterative M extension enabled by defining EX_MULDIV_EN.
module ex_stage_mc #(
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rst,
   ex_stage_mc_if.slave ex
);
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_OP  = 7'b0110011;
   localparam logic [6:0] OP_SYS = 7'b1110011;

   logic [XLEN-1:0] a, opb, alu, pc4, base_c, m_res;
   logic [XLEN-1:0] c_q, c_d;
   logic [5:0]      shamt;
   logic            is_m, alt, br, base_j;
   logic            busy_w, accept, m_go, m_done;
   logic            ov_q, ov_d, j_q, j_d;

   assign a      = ex.data1;
   assign accept = ex.in_valid & ~busy_w & ~ex.flush;

   always_comb begin
      is_m  = (ex.opcode == OP_OP) && (ex.funct7 == 7'b0000001);
      opb   = (ex.opcode == OP_OP) ? ex.data2 : ex.imm;
      shamt = opb[5:0] & ((XLEN == 64) ? 6'h3f : 6'h1f);
      alt   = ex.funct7[5];
      pc4   = ex.pc + XLEN'(4);
      alu   = '0;
      case (ex.funct3)
         3'b000:  alu = (ex.opcode == OP_OP && alt) ? a - opb : a + opb;
         3'b001:  alu = a << shamt;
         3'b010:  alu = XLEN'($signed(a) < $signed(opb));
         3'b011:  alu = XLEN'(a < opb);
         3'b100:  alu = a ^ opb;
         3'b101:  alu = alt ? XLEN'($signed(a) >>> shamt) : a >> shamt;
         3'b110:  alu = a | opb;
         default: alu = a & opb;
      endcase
      br = 1'b0;
      case (ex.funct3)
         3'b000:  br = a == ex.data2;
         3'b001:  br = a != ex.data2;
         3'b100:  br = $signed(a) < $signed(ex.data2);
         3'b101:  br = $signed(a) >= $signed(ex.data2);
         3'b110:  br = a < ex.data2;
         3'b111:  br = a >= ex.data2;
         default: br = 1'b0;
      endcase
      // branches report their target; SYSTEM passes the CSR read value z_
      base_c = '0;
      base_j = 1'b0;
      unique case (1'b1)
         ex.opcode == OP_LUI: base_c = ex.imm;
         ex.opcode == OP_AUI: base_c = ex.pc + ex.imm;
         ex.opcode == OP_JAL,
         ex.opcode == OP_JLR: begin
            base_c = pc4;
            base_j = 1'b1;
         end
         ex.opcode == OP_BR: begin
            base_c = ex.pc + ex.imm;
            base_j = br;
         end
         ex.opcode == OP_LD,
         ex.opcode == OP_ST: base_c = a + ex.imm;
         ex.opcode == OP_IMM: base_c = alu;
         ex.opcode == OP_OP && !is_m: base_c = alu;
         ex.opcode == OP_SYS: base_c = ex.z_;
         default: ;
      endcase
   end

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int CW = $clog2(XLEN) + 1;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, dv_q, dv_d, a_q, a_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d, nega_q, nega_d, dz_q, dz_d;
   logic [XLEN-1:0]   nhi, nlo, quo, rem;
   logic [XLEN:0]     sum, shl, dif;
   logic [2*XLEN-1:0] prod;
   logic              sa, sb, na, nb, last;

   assign busy_w = state_q == RUN;
   assign m_go   = is_m;
   assign last   = cnt_q == CW'(XLEN - 1);
   assign m_done = busy_w && last && !ex.flush;

   always_comb begin
      sa = ex.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
      sb = ex.funct3 inside {3'b001, 3'b100, 3'b110};
      na = sa & a[XLEN-1];
      nb = sb & ex.data2[XLEN-1];
      // one shift-add or one restoring-divide step per cycle
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
      shl = {hi_q, lo_q[XLEN-1]};
      dif = shl - {1'b0, dv_q};
      if (!f3_q[2]) begin
         nhi = sum[XLEN:1];
         nlo = {sum[0], lo_q[XLEN-1:1]};
      end else if (!dif[XLEN]) begin
         nhi = dif[XLEN-1:0];
         nlo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         nhi = shl[XLEN-1:0];
         nlo = {lo_q[XLEN-2:0], 1'b0};
      end
      prod = {nhi, nlo};
      if (neg_q) prod = -prod;
      quo = neg_q ? -nlo : nlo;
      rem = nega_q ? -nhi : nhi;
      if (dz_q) begin
         quo = '1;
         rem = a_q;
      end
      if (!f3_q[2])
         m_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else
         m_res = f3_q[1] ? rem : quo;

      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dv_d    = dv_q;
      a_d     = a_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      nega_d  = nega_q;
      dz_d    = dz_q;
      if (ex.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         hi_d  = nhi;
         lo_d  = nlo;
         cnt_d = cnt_q + 1'b1;
         if (last) begin
            state_d = DONE;
            cnt_d   = '0;
         end
      end else if (accept && is_m) begin
         state_d = RUN;
         cnt_d   = '0;
         hi_d    = '0;
         lo_d    = na ? -a : a;
         dv_d    = nb ? -ex.data2 : ex.data2;
         a_d     = a;
         f3_d    = ex.funct3;
         neg_d   = na ^ nb;
         nega_d  = na;
         dz_d    = ex.data2 == '0;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dv_q    <= '0;
         a_q     <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         nega_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dv_q    <= dv_d;
         a_q     <= a_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         nega_q  <= nega_d;
         dz_q    <= dz_d;
      end
   end
`else
   assign busy_w = 1'b0;
   assign m_go   = 1'b0;
   assign m_done = 1'b0;
   assign m_res  = '0;
`endif

   always_comb begin
      ov_d = 1'b0;
      c_d  = c_q;
      j_d  = j_q;
      if (m_done) begin
         ov_d = 1'b1;
         c_d  = m_res;
         j_d  = 1'b0;
      end else if (accept && !m_go) begin
         ov_d = 1'b1;
         c_d  = base_c;
         j_d  = base_j;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_q <= 1'b0;
         c_q  <= '0;
         j_q  <= 1'b0;
      end else begin
         ov_q <= ov_d;
         c_q  <= c_d;
         j_q  <= j_d;
      end
   end

   assign ex.busy      = busy_w;
   assign ex.out_valid = ov_q;
   assign ex.jump      = j_q;
   assign ex.c         = c_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: scoreboard bench for ex_stage_mc covering base ops,
// flush/reset, and the iterative M unit when EX_MULDIV_EN is defined.
module tb_ex_stage_mc;
   localparam int XLEN = 32;
   localparam logic [6:0] O_OP  = 7'b0110011;
   localparam logic [6:0] O_IMM = 7'b0010011;
   localparam logic [6:0] O_BR  = 7'b1100011;
   localparam logic [6:0] O_JAL = 7'b1101111;
   localparam logic [6:0] O_LUI = 7'b0110111;
   localparam logic [6:0] O_AUI = 7'b0010111;
   localparam logic [6:0] O_ST  = 7'b0100011;
   localparam logic [6:0] O_SYS = 7'b1110011;
   localparam logic [6:0] F7M   = 7'b0000001;
   localparam logic [6:0] F7A   = 7'b0100000;

   typedef struct {
      logic [31:0] c;
      logic        j;
   } exp_t;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] pc, d1, d2, imm, z, c;
      logic        j;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   ex_stage_mc_if #(.XLEN(XLEN)) bus ();
   ex_stage_mc #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .ex(bus));

   always #5 clk = ~clk;

   function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] pc,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input logic [31:0] z,
                              input logic [31:0] c, input logic j);
      op_t o;
      o.opc = opc; o.f3 = f3; o.f7 = f7; o.pc = pc;
      o.d1 = d1; o.d2 = d2; o.imm = imm; o.z = z;
      o.c = c; o.j = j;
      return o;
   endfunction

   task automatic idle_bus();
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
      bus.pc = '0; bus.data1 = '0; bus.data2 = '0;
      bus.imm = '0; bus.z_ = '0;
   endtask

   task automatic drive(input op_t o);
      bus.in_valid = 1'b1;
      bus.opcode = o.opc; bus.funct3 = o.f3; bus.funct7 = o.f7;
      bus.pc = o.pc; bus.data1 = o.d1; bus.data2 = o.d2;
      bus.imm = o.imm; bus.z_ = o.z;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (bus.out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      exp_t e;
      idle_bus();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.jump !== 1'b0 || bus.c !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b ov=%b j=%b c=%h, required 0 0 0 0",
                  bus.busy, bus.out_valid, bus.jump, bus.c);
      end
      rst = 1'b0;
      drive(mk(O_OP, 3'b000, 7'h0, 0, 3, 4, 0, 0, 7, 0));
      sb.push_back('{32'd7, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c || bus.jump !== e.j) begin
         errors++;
         $display("FAIL first_accept: ov=%b c=%h j=%b, required 1 %h %b",
                  bus.out_valid, bus.c, bus.jump, e.c, e.j);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.c !== 32'd7) begin
         errors++;
         $display("FAIL single_pulse: ov=%b c=%h, required 0 00000007",
                  bus.out_valid, bus.c);
      end
   endtask

   task automatic test_alu();
      op_t  ops[$];
      exp_t e;
      ops.push_back(mk(O_IMM, 3'b000, 7'h7f, 0, 5, 0, 32'hFFFFFFF9, 0, 32'hFFFFFFFE, 0));
      ops.push_back(mk(O_BR, 3'b000, 7'h0, 32'h100, 32'h1234, 32'h1234, 32'h20, 0, 32'h120, 1));
      ops.push_back(mk(O_BR, 3'b100, 7'h0, 32'h100, 32'hFFFFFFFF, 1, 32'h20, 0, 32'h120, 1));
      ops.push_back(mk(O_BR, 3'b110, 7'h0, 32'h100, 32'hFFFFFFFF, 1, 32'h20, 0, 32'h120, 0));
      ops.push_back(mk(O_BR, 3'b001, 7'h0, 32'h100, 5, 5, 32'h20, 0, 32'h120, 0));
      ops.push_back(mk(O_OP, 3'b000, F7A, 0, 10, 3, 0, 0, 7, 0));
      ops.push_back(mk(O_IMM, 3'b101, F7A, 0, 32'h80000000, 0, 32'h404, 0, 32'hF8000000, 0));
      ops.push_back(mk(O_OP, 3'b101, 7'h0, 0, 32'h80000000, 4, 0, 0, 32'h08000000, 0));
      ops.push_back(mk(O_IMM, 3'b001, 7'h0, 0, 1, 0, 3, 0, 8, 0));
      ops.push_back(mk(O_OP, 3'b010, 7'h0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 0));
      ops.push_back(mk(O_OP, 3'b011, 7'h0, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0));
      ops.push_back(mk(O_OP, 3'b100, 7'h0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 32'hFF00, 0));
      ops.push_back(mk(O_LUI, 3'b000, 7'h0, 0, 0, 0, 32'h12345000, 0, 32'h12345000, 0));
      ops.push_back(mk(O_AUI, 3'b000, 7'h0, 32'h1000, 0, 0, 32'h2000, 0, 32'h3000, 0));
      ops.push_back(mk(O_JAL, 3'b000, 7'h0, 32'h200, 0, 0, 32'h40, 0, 32'h204, 1));
      ops.push_back(mk(O_ST, 3'b010, 7'h0, 0, 32'h100, 9, 8, 0, 32'h108, 0));
      ops.push_back(mk(O_SYS, 3'b001, 7'h0, 0, 0, 0, 0, 32'hABCD, 32'hABCD, 0));
`ifndef EX_MULDIV_EN
      ops.push_back(mk(O_OP, 3'b000, F7M, 0, 6, 7, 0, 0, 0, 0));
      ops.push_back(mk(O_OP, 3'b100, F7M, 0, 6, 7, 0, 0, 0, 0));
`endif
      for (int i = 0; i < ops.size(); i++) begin
         drive(ops[i]);
         sb.push_back('{ops[i].c, ops[i].j});
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL alu_busy_%0d: busy=%b, required 0", i, bus.busy);
         end
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.c !== e.c || bus.jump !== e.j) begin
            errors++;
            $display("FAIL alu_%0d: ov=%b c=%h j=%b, required 1 %h %b",
                     i, bus.out_valid, bus.c, bus.jump, e.c, e.j);
         end
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_flush_rst();
      exp_t e;
      drive(mk(O_OP, 3'b000, 7'h0, 0, 5, 6, 0, 0, 11, 0));
      sb.push_back('{32'd11, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c) begin
         errors++;
         $display("FAIL flush_pre: ov=%b c=%h, required 1 %h",
                  bus.out_valid, bus.c, e.c);
      end
      drive(mk(O_OP, 3'b000, 7'h0, 0, 5, 5, 0, 0, 10, 0));
      bus.flush = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.c !== 32'd11 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_block: ov=%b c=%h busy=%b, required 0 0000000b 0",
                  bus.out_valid, bus.c, bus.busy);
      end
      bus.flush = 1'b0;
      sb.push_back('{32'd10, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c) begin
         errors++;
         $display("FAIL flush_retry: ov=%b c=%h, required 1 %h",
                  bus.out_valid, bus.c, e.c);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.jump !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: ov=%b c=%h j=%b, required 0 0 0",
                  bus.out_valid, bus.c, bus.jump);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

`ifdef EX_MULDIV_EN
   task automatic test_mulhu();
      exp_t e;
      int   n;
      drive(mk(O_OP, 3'b011, F7M, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 0));
      sb.push_back('{32'hFFFFFFFE, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL mulhu_busy: cycles=%0d, required 32", n);
      end
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c || bus.jump !== 1'b0) begin
         errors++;
         $display("FAIL mulhu_result: ov=%b c=%h j=%b, required 1 %h 0",
                  bus.out_valid, bus.c, bus.jump, e.c);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.c !== 32'hFFFFFFFE) begin
         errors++;
         $display("FAIL mulhu_pulse: ov=%b c=%h, required 0 fffffffe",
                  bus.out_valid, bus.c);
      end
   endtask

   task automatic test_muldiv();
      op_t         ops[$];
      exp_t        e;
      bit          ok;
      logic [31:0] ra, rb;
      logic [63:0] p;
      ops.push_back(mk(O_OP, 3'b100, F7M, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000, 0));
      ops.push_back(mk(O_OP, 3'b110, F7M, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0));
      ops.push_back(mk(O_OP, 3'b110, F7M, 0, 7, 0, 0, 0, 7, 0));
      ops.push_back(mk(O_OP, 3'b101, F7M, 0, 5, 0, 0, 0, 32'hFFFFFFFF, 0));
      ops.push_back(mk(O_OP, 3'b100, F7M, 0, 32'hFFFFFFF8, 0, 0, 0, 32'hFFFFFFFF, 0));
      ops.push_back(mk(O_OP, 3'b110, F7M, 0, 32'hFFFFFFF8, 0, 0, 0, 32'hFFFFFFF8, 0));
      ops.push_back(mk(O_OP, 3'b100, F7M, 0, 32'hFFFFFFF9, 2, 0, 0, 32'hFFFFFFFD, 0));
      ops.push_back(mk(O_OP, 3'b110, F7M, 0, 32'hFFFFFFF9, 2, 0, 0, 32'hFFFFFFFF, 0));
      ops.push_back(mk(O_OP, 3'b111, F7M, 0, 100, 7, 0, 0, 2, 0));
      ops.push_back(mk(O_OP, 3'b101, F7M, 0, 100, 7, 0, 0, 14, 0));
      ops.push_back(mk(O_OP, 3'b000, F7M, 0, 32'hFFFFFFFD, 5, 0, 0, 32'hFFFFFFF1, 0));
      ops.push_back(mk(O_OP, 3'b001, F7M, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0));
      ops.push_back(mk(O_OP, 3'b001, F7M, 0, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 0));
      ops.push_back(mk(O_OP, 3'b010, F7M, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0));
      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = $urandom | 32'h1;
         p  = {32'h0, ra} * {32'h0, rb};
         ops.push_back(mk(O_OP, 3'b011, F7M, 0, ra, rb, 0, 0, p[63:32], 0));
         ops.push_back(mk(O_OP, 3'b111, F7M, 0, ra, rb, 0, 0, ra % rb, 0));
      end
      for (int i = 0; i < ops.size(); i++) begin
         drive(ops[i]);
         sb.push_back('{ops[i].c, ops[i].j});
         @(negedge clk);
         bus.in_valid = 1'b0;
         wait_valid(XLEN + 5, ok);
         e = sb.pop_front();
         checks++;
         if (!ok || bus.c !== e.c || bus.jump !== e.j) begin
            errors++;
            $display("FAIL muldiv_%0d: ov=%b c=%h j=%b, required 1 %h %b",
                     i, ok, bus.c, bus.jump, e.c, e.j);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_abort();
      exp_t e;
      bit   seen;
      drive(mk(O_OP, 3'b101, F7M, 0, 100, 7, 0, 0, 14, 0));
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.c !== 32'h0) begin
         errors++;
         $display("FAIL rst_abort: busy=%b ov=%b c=%h, required 0 0 0",
                  bus.busy, bus.out_valid, bus.c);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < XLEN + 5; i++) begin
         if (bus.out_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rst_no_result: stray out_valid=1, required none");
      end
      drive(mk(O_OP, 3'b000, 7'h0, 0, 20, 22, 0, 0, 42, 0));
      sb.push_back('{32'd42, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c) begin
         errors++;
         $display("FAIL rst_then_add: ov=%b c=%h, required 1 %h",
                  bus.out_valid, bus.c, e.c);
      end
      drive(mk(O_OP, 3'b101, F7M, 0, 100, 7, 0, 0, 14, 0));
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.c !== 32'd42) begin
         errors++;
         $display("FAIL flush_abort: busy=%b ov=%b c=%h, required 0 0 0000002a",
                  bus.busy, bus.out_valid, bus.c);
      end
      seen = 1'b0;
      for (int i = 0; i < XLEN + 5; i++) begin
         if (bus.out_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen || bus.c !== 32'd42) begin
         errors++;
         $display("FAIL flush_no_result: seen=%b c=%h, required 0 0000002a",
                  seen, bus.c);
      end
      drive(mk(O_OP, 3'b000, 7'h0, 0, 1, 1, 0, 0, 2, 0));
      sb.push_back('{32'd2, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c) begin
         errors++;
         $display("FAIL flush_then_add: ov=%b c=%h, required 1 %h",
                  bus.out_valid, bus.c, e.c);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   ok;
      drive(mk(O_OP, 3'b000, F7M, 0, 6, 7, 0, 0, 42, 0));
      sb.push_back('{32'd42, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(XLEN + 5, ok);
      drive(mk(O_OP, 3'b000, 7'h0, 0, 1, 2, 0, 0, 3, 0));
      sb.push_back('{32'd3, 1'b0});
      e = sb.pop_front();
      checks++;
      if (!ok || bus.c !== e.c || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_mul: ov=%b c=%h busy=%b, required 1 %h 0",
                  ok, bus.c, bus.busy, e.c);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.c !== e.c) begin
         errors++;
         $display("FAIL b2b_add: ov=%b c=%h, required 1 %h",
                  bus.out_valid, bus.c, e.c);
      end
      @(negedge clk);
      drive(mk(O_OP, 3'b000, F7M, 0, 3, 3, 0, 0, 9, 0));
      sb.push_back('{32'd9, 1'b0});
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(XLEN + 5, ok);
      drive(mk(O_OP, 3'b000, F7M, 0, 2, 5, 0, 0, 10, 0));
      sb.push_back('{32'd10, 1'b0});
      e = sb.pop_front();
      checks++;
      if (!ok || bus.c !== e.c) begin
         errors++;
         $display("FAIL b2b_mul1: ov=%b c=%h, required 1 %h", ok, bus.c, e.c);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_mul2_run: busy=%b ov=%b, required 1 0",
                  bus.busy, bus.out_valid);
      end
      wait_valid(XLEN + 5, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || bus.c !== e.c) begin
         errors++;
         $display("FAIL b2b_mul2: ov=%b c=%h, required 1 %h", ok, bus.c, e.c);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_flush_rst();
`ifdef EX_MULDIV_EN
      test_mulhu();
      test_muldiv();
      test_abort();
      test_back_to_back();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: left=%0d, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
